// File: rtl/wbuf_seq_ctrl_if.sv
// Weight-buffer sequencer bus: DDR beat handshake plus buffer write/read-start signals.
interface wbuf_seq_ctrl_if #(
  parameter int ADDR_LEN     = 16,
  parameter int DDR_DATA_LEN = 256,
  parameter int BUFFER_NUM   = 32
);
  logic                    ddr_valid;
  logic [DDR_DATA_LEN-1:0] ddr_data;
  logic                    ddr_ready;
  logic [DDR_DATA_LEN-1:0] wb_data_wr;
  logic [ADDR_LEN-1:0]     wb_wr_addr;
  logic [BUFFER_NUM-1:0]   wb_wr_en;
  logic                    wb_rd_conf;
  logic [ADDR_LEN-1:0]     wb_st_rd_addr;
  logic                    wb_ker_en;

  modport master (
    input  ddr_valid, ddr_data, wb_ker_en,
    output ddr_ready, wb_data_wr, wb_wr_addr, wb_wr_en, wb_rd_conf, wb_st_rd_addr
  );

  modport slave (
    output ddr_valid, ddr_data, wb_ker_en,
    input  ddr_ready, wb_data_wr, wb_wr_addr, wb_wr_en, wb_rd_conf, wb_st_rd_addr
  );
endinterface

// File: rtl/wbuf_seq_ctrl.sv
// Weight-buffer sequencer: fills bank groups from DDR beats (LOAD) and walks
// kernel-set read starts with a 9-address stride (RUN_ISSUE/RUN_WAIT).
module wbuf_seq_ctrl #(
  parameter int ADDR_LEN     = 16,
  parameter int DDR_DATA_LEN = 256,
  parameter int DATA_LEN     = 64,
  parameter int BUFFER_NUM   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic [ADDR_LEN-1:0] load_base,
  input  logic [ADDR_LEN-1:0] load_rows,
  input  logic                run_start,
  input  logic [ADDR_LEN-1:0] run_base,
  input  logic [15:0]         run_count,
  output logic                ker_valid,
  output logic                busy,
  output logic                done,
  wbuf_seq_ctrl_if.master     bus
);

  localparam int BPG = DDR_DATA_LEN / DATA_LEN;   // banks written per beat
  localparam int G   = BUFFER_NUM / BPG;          // write groups per row
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam logic [GW-1:0]         GRP_LAST   = GW'(G - 1);
  localparam logic [BUFFER_NUM-1:0] GRP_MASK   = BUFFER_NUM'({BPG{1'b1}});
  localparam logic [ADDR_LEN-1:0]   KER_STRIDE = ADDR_LEN'(9);

  typedef enum logic [2:0] {IDLE, LOAD, RUN_ISSUE, RUN_WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_LEN-1:0]     load_base_q, load_rows_q, row_q;
  logic [GW-1:0]           grp_q;
  logic [15:0]             run_count_q, set_q;
  logic [ADDR_LEN-1:0]     rd_addr_q;
  logic                    wait_first_q;
  logic [DDR_DATA_LEN-1:0] wr_data_q;
  logic [ADDR_LEN-1:0]     wr_addr_q;
  logic [BUFFER_NUM-1:0]   wr_en_q;
  logic                    ddr_ready, rd_conf;

  logic beat_acc, last_beat, ker_take, last_set;

  assign beat_acc  = (state_q == LOAD) && bus.ddr_valid;
  assign last_beat = beat_acc && (grp_q == GRP_LAST) &&
                     (row_q == load_rows_q - ADDR_LEN'(1));
  // First RUN_WAIT cycle still sees the previous set's ker_en level, so skip it.
  assign ker_take  = (state_q == RUN_WAIT) && !wait_first_q && bus.wb_ker_en;
  assign last_set  = (set_q + 16'd1) == run_count_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; load_start has priority, starts outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_start)     state_d = (load_rows == '0) ? DONE : LOAD;
        else if (run_start) state_d = (run_count == 16'd0) ? DONE : RUN_ISSUE;
      end
      LOAD:      if (last_beat) state_d = DONE;
      RUN_ISSUE: state_d = RUN_WAIT;
      RUN_WAIT:  if (ker_take) state_d = last_set ? DONE : RUN_ISSUE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State-decoded control outputs.
  always_comb begin
    ddr_ready = 1'b0;
    rd_conf   = 1'b0;
    ker_valid = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    case (state_q)
      LOAD:      ddr_ready = 1'b1;
      RUN_ISSUE: rd_conf   = 1'b1;
      RUN_WAIT:  ker_valid = ker_take;
      default: ;
    endcase
  end

  // Job latches, beat/set counters and the registered buffer write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_base_q  <= '0;
      load_rows_q  <= '0;
      row_q        <= '0;
      grp_q        <= '0;
      run_count_q  <= '0;
      set_q        <= '0;
      rd_addr_q    <= '0;
      wait_first_q <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= '0;
    end else begin
      wr_en_q      <= '0;
      wait_first_q <= (state_q == RUN_ISSUE);
      case (state_q)
        IDLE: begin
          if (load_start) begin
            load_base_q <= load_base;
            load_rows_q <= load_rows;
            row_q       <= '0;
            grp_q       <= '0;
          end else if (run_start) begin
            rd_addr_q   <= run_base;
            run_count_q <= run_count;
            set_q       <= '0;
          end
        end
        LOAD: begin
          if (beat_acc) begin
            wr_data_q <= bus.ddr_data;
            wr_addr_q <= load_base_q + row_q;
            wr_en_q   <= GRP_MASK << (BPG * int'(grp_q));
            if (grp_q == GRP_LAST) begin
              grp_q <= '0;
              row_q <= row_q + ADDR_LEN'(1);
            end else begin
              grp_q <= grp_q + GW'(1);
            end
          end
        end
        RUN_WAIT: begin
          if (ker_take) begin
            set_q     <= set_q + 16'd1;
            rd_addr_q <= rd_addr_q + KER_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ddr_ready     = ddr_ready;
  assign bus.wb_rd_conf    = rd_conf;
  assign bus.wb_st_rd_addr = rd_addr_q;
  assign bus.wb_data_wr    = wr_data_q;
  assign bus.wb_wr_addr    = wr_addr_q;
  assign bus.wb_wr_en      = wr_en_q;

endmodule

// File: tb/tb_wbuf_seq_ctrl.sv
// Directed bench for wbuf_seq_ctrl: load sequences, kernel-read walks, start priority, mid-job reset.
module tb_wbuf_seq_ctrl;
  localparam int AL = 16;
  localparam int DL = 256;
  localparam int WL = 64;
  localparam int BN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, run_start;
  logic [15:0] load_base, load_rows, run_base, run_count;
  logic        ker_valid, busy, done;

  always #5 clk = ~clk;

  wbuf_seq_ctrl_if #(.ADDR_LEN(AL), .DDR_DATA_LEN(DL), .BUFFER_NUM(BN)) bus ();

  wbuf_seq_ctrl #(.ADDR_LEN(AL), .DDR_DATA_LEN(DL), .DATA_LEN(WL), .BUFFER_NUM(BN)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_rows(load_rows),
    .run_start(run_start), .run_base(run_base), .run_count(run_count),
    .ker_valid(ker_valid), .busy(busy), .done(done), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // observations gathered by the job drivers
  int              obs_nw, obs_ready, obs_done, obs_gap, obs_conf, obs_overlap;
  int              obs_lag, obs_timeout, obs_ker;
  logic            obs_busy_end;
  logic [BN-1:0]   obs_en [16];
  logic [15:0]     obs_ad [16];
  logic [DL-1:0]   obs_dt [16];
  logic [15:0]     obs_addr [8];
  int              obs_since [8];

  function automatic logic [DL-1:0] pat(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n);
    return {8{w}};
  endfunction

  task automatic load_job(input logic [15:0] base, input logic [15:0] rows,
                          input bit toggle, input bit with_run, input int run_pulse_at);
    bit prev_acc, v;
    int beat, last_acc, done_idx, nbeats;
    prev_acc = 0; beat = 0; last_acc = -1; done_idx = -1; nbeats = int'(rows) * 8;
    obs_nw = 0; obs_ready = 0; obs_done = 0; obs_gap = 0; obs_conf = 0; obs_overlap = 0;
    load_base = base; load_rows = rows; load_start = 1'b1;
    run_start = with_run; run_base = 16'h0200; run_count = 16'd1;
    bus.ddr_valid = 1'b0; bus.ddr_data = '0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      load_start = 1'b0;
      run_start  = (c == run_pulse_at);
      if (bus.wb_wr_en != '0) begin
        if (!prev_acc) obs_gap++;
        if (obs_nw < 16) begin
          obs_en[obs_nw] = bus.wb_wr_en;
          obs_ad[obs_nw] = bus.wb_wr_addr;
          obs_dt[obs_nw] = bus.wb_data_wr;
        end
        obs_nw++;
      end else if (prev_acc) obs_gap++;
      if (bus.ddr_ready) obs_ready++;
      if (bus.wb_rd_conf) obs_conf++;
      if ((bus.wb_rd_conf || ker_valid) && bus.wb_wr_en != '0) obs_overlap++;
      if (done) begin obs_done++; done_idx = c; end
      v = (beat < nbeats) && (!toggle || (obs_ready % 2 == 0));
      bus.ddr_valid = v;
      bus.ddr_data  = pat(beat);
      prev_acc = bus.ddr_ready && v;
      if (prev_acc) begin last_acc = c; beat++; end
      obs_busy_end = busy;
      if (done_idx >= 0 && c >= done_idx + 2) break;
    end
    bus.ddr_valid = 1'b0; run_start = 1'b0;
    obs_timeout = (done_idx < 0) ? 1 : 0;
    obs_lag = done_idx - last_acc;
  endtask

  // buffer model: wb_ker_en rises lat cycles after wb_rd_conf, drops at the next read start
  task automatic run_job(input logic [15:0] base, input logic [15:0] cnt, input int lat);
    int since, done_idx;
    since = -1; done_idx = -1;
    obs_conf = 0; obs_ker = 0; obs_done = 0; obs_overlap = 0; obs_gap = 0;
    run_base = base; run_count = cnt; run_start = 1'b1; bus.wb_ker_en = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      run_start = 1'b0;
      if (bus.wb_rd_conf) begin
        if (obs_conf < 8) obs_addr[obs_conf] = bus.wb_st_rd_addr;
        obs_conf++;
        since = 0;
        bus.wb_ker_en = 1'b0;
      end else if (since >= 0) since++;
      if (since >= lat) bus.wb_ker_en = 1'b1;
      #1;
      if (ker_valid) begin
        if (obs_ker < 8) obs_since[obs_ker] = since;
        obs_ker++;
      end
      if (bus.wb_wr_en != '0) obs_gap++;
      if ((bus.wb_rd_conf || ker_valid) && bus.wb_wr_en != '0) obs_overlap++;
      if (done) begin
        obs_done++; done_idx = c; since = -1; bus.wb_ker_en = 1'b0;
      end
      obs_busy_end = busy;
      if (done_idx >= 0 && c >= done_idx + 2) break;
    end
    bus.wb_ker_en = 1'b0;
    obs_timeout = (done_idx < 0) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; run_start = 1'b0;
    load_base = '0; load_rows = '0; run_base = '0; run_count = '0;
    bus.ddr_valid = 1'b0; bus.ddr_data = '0; bus.wb_ker_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.ddr_ready, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_rd_conf, bus.wb_st_rd_addr,
         ker_valid, busy, done} !== '0 || bus.wb_data_wr !== '0) begin
      n_fail++;
      $display("FAIL reset_zero: ready=%b en=%h addr=%h conf=%b st=%h kv=%b busy=%b done=%b, required all zero",
               bus.ddr_ready, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_rd_conf, bus.wb_st_rd_addr, ker_valid, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_load_b2b();
    load_job(16'h0010, 16'd2, 1'b0, 1'b0, -1);
    n_checks++;
    if (obs_nw !== 16) begin n_fail++; $display("FAIL b2b_writes: got %0d required 16", obs_nw); end
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (obs_en[n] !== (32'hF << (4 * (n % 8))) || obs_ad[n] !== 16'(16'h0010 + n / 8) || obs_dt[n] !== pat(n)) begin
        n_fail++;
        $display("FAIL b2b_write%0d: en=%h addr=%h required en=%h addr=%h", n, obs_en[n], obs_ad[n],
                 32'hF << (4 * (n % 8)), 16'(16'h0010 + n / 8));
      end
    end
    n_checks++;
    if (obs_ready !== 16) begin n_fail++; $display("FAIL b2b_load_cycles: got %0d required 16", obs_ready); end
    n_checks++;
    if (obs_done !== 1 || obs_lag !== 1 || obs_timeout !== 0) begin
      n_fail++; $display("FAIL b2b_done: count=%0d lag=%0d timeout=%0d required 1/1/0", obs_done, obs_lag, obs_timeout);
    end
    n_checks++;
    if (obs_gap !== 0 || obs_busy_end !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap_idle: gap=%0d busy=%b required 0/0", obs_gap, obs_busy_end);
    end
  endtask

  task automatic test_load_toggle();
    load_job(16'h0010, 16'd2, 1'b1, 1'b0, -1);
    n_checks++;
    if (obs_nw !== 16) begin n_fail++; $display("FAIL tog_writes: got %0d required 16", obs_nw); end
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (obs_en[n] !== (32'hF << (4 * (n % 8))) || obs_ad[n] !== 16'(16'h0010 + n / 8) || obs_dt[n] !== pat(n)) begin
        n_fail++;
        $display("FAIL tog_write%0d: en=%h addr=%h required en=%h addr=%h", n, obs_en[n], obs_ad[n],
                 32'hF << (4 * (n % 8)), 16'(16'h0010 + n / 8));
      end
    end
    n_checks++;
    if (obs_ready !== 32) begin n_fail++; $display("FAIL tog_load_cycles: got %0d required 32", obs_ready); end
    n_checks++;
    if (obs_gap !== 0) begin n_fail++; $display("FAIL tog_gap_en: got %0d required 0", obs_gap); end
    n_checks++;
    if (obs_done !== 1 || obs_timeout !== 0) begin
      n_fail++; $display("FAIL tog_done: count=%0d timeout=%0d required 1/0", obs_done, obs_timeout);
    end
  endtask

  task automatic test_load_zero();
    load_job(16'h0030, 16'd0, 1'b0, 1'b0, -1);
    n_checks++;
    if (obs_nw !== 0 || obs_ready !== 0 || obs_done !== 1) begin
      n_fail++; $display("FAIL zero_rows: writes=%0d ready=%0d done=%0d required 0/0/1", obs_nw, obs_ready, obs_done);
    end
  endtask

  task automatic test_run();
    run_job(16'h0100, 16'd3, 11);
    n_checks++;
    if (obs_conf !== 3) begin n_fail++; $display("FAIL run_conf_count: got %0d required 3", obs_conf); end
    n_checks++;
    if (obs_addr[0] !== 16'h0100 || obs_addr[1] !== 16'h0109 || obs_addr[2] !== 16'h0112) begin
      n_fail++; $display("FAIL run_addrs: got %h %h %h required 0100 0109 0112", obs_addr[0], obs_addr[1], obs_addr[2]);
    end
    n_checks++;
    if (obs_ker !== 3 || obs_since[0] !== 11 || obs_since[2] !== 11) begin
      n_fail++; $display("FAIL run_ker_valid: count=%0d lat0=%0d lat2=%0d required 3/11/11", obs_ker, obs_since[0], obs_since[2]);
    end
    n_checks++;
    if (obs_done !== 1 || obs_timeout !== 0 || obs_overlap !== 0 || obs_gap !== 0) begin
      n_fail++; $display("FAIL run_done: done=%0d timeout=%0d overlap=%0d wr=%0d required 1/0/0/0",
                         obs_done, obs_timeout, obs_overlap, obs_gap);
    end
  endtask

  task automatic test_run_wrap();
    run_job(16'hFFFB, 16'd2, 11);
    n_checks++;
    if (obs_conf !== 2 || obs_addr[0] !== 16'hFFFB || obs_addr[1] !== 16'h0004) begin
      n_fail++; $display("FAIL wrap_addrs: n=%0d got %h %h required 2 FFFB 0004", obs_conf, obs_addr[0], obs_addr[1]);
    end
    n_checks++;
    if (obs_ker !== 2 || obs_done !== 1) begin
      n_fail++; $display("FAIL wrap_done: ker=%0d done=%0d required 2/1", obs_ker, obs_done);
    end
  endtask

  task automatic test_run_zero();
    run_job(16'h0100, 16'd0, 11);
    n_checks++;
    if (obs_conf !== 0 || obs_done !== 1 || obs_ker !== 0) begin
      n_fail++; $display("FAIL run_zero: conf=%0d done=%0d ker=%0d required 0/1/0", obs_conf, obs_done, obs_ker);
    end
  endtask

  task automatic test_run_first_ignore();
    run_job(16'h0050, 16'd1, 1);
    n_checks++;
    if (obs_ker !== 1 || obs_since[0] !== 2 || obs_addr[0] !== 16'h0050) begin
      n_fail++; $display("FAIL first_wait_ignore: ker=%0d at=%0d addr=%h required 1/2/0050", obs_ker, obs_since[0], obs_addr[0]);
    end
  endtask

  task automatic test_start_priority();
    load_job(16'h0010, 16'd2, 1'b0, 1'b1, 5);
    n_checks++;
    if (obs_nw !== 16 || obs_ad[0] !== 16'h0010 || obs_ad[15] !== 16'h0011) begin
      n_fail++; $display("FAIL prio_load: writes=%0d a0=%h a15=%h required 16/0010/0011", obs_nw, obs_ad[0], obs_ad[15]);
    end
    n_checks++;
    if (obs_conf !== 0 || obs_busy_end !== 1'b0) begin
      n_fail++; $display("FAIL prio_run_dropped: conf=%0d busy=%b required 0/0", obs_conf, obs_busy_end);
    end
  endtask

  task automatic test_reset_mid_load();
    load_base = 16'h0010; load_rows = 16'd2; load_start = 1'b1;
    bus.ddr_valid = 1'b1; bus.ddr_data = pat(0);
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; load_start = 1'b0; end
    n_checks++;
    if (busy !== 1'b1 || bus.wb_wr_en === '0) begin
      n_fail++; $display("FAIL midload_active: busy=%b en=%h required 1/nonzero", busy, bus.wb_wr_en);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.ddr_ready, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_rd_conf, bus.wb_st_rd_addr,
         ker_valid, busy, done} !== '0 || bus.wb_data_wr !== '0) begin
      n_fail++;
      $display("FAIL midload_reset_zero: ready=%b en=%h addr=%h conf=%b st=%h kv=%b busy=%b done=%b, required all zero",
               bus.ddr_ready, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_rd_conf, bus.wb_st_rd_addr, ker_valid, busy, done);
    end
    rst_n = 1'b1; bus.ddr_valid = 1'b0;
    @(posedge clk); #1;
    load_job(16'h0020, 16'd1, 1'b0, 1'b0, -1);
    n_checks++;
    if (obs_nw !== 8 || obs_en[0] !== 32'h0000000F || obs_ad[0] !== 16'h0020 || obs_en[7] !== 32'hF0000000
        || obs_dt[7] !== pat(7) || obs_done !== 1) begin
      n_fail++; $display("FAIL midload_rerun: writes=%0d en0=%h a0=%h en7=%h done=%0d required 8/0000000f/0020/f0000000/1",
                         obs_nw, obs_en[0], obs_ad[0], obs_en[7], obs_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    seen = -1;
    run_base = 16'h0300; run_count = 16'd2; run_start = 1'b1; bus.wb_ker_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      run_start = 1'b0;
      if (bus.wb_rd_conf) seen = c;
      if (seen >= 0 && c == seen + 3) break;
    end
    n_checks++;
    if (seen < 0 || busy !== 1'b1 || bus.wb_st_rd_addr !== 16'h0300) begin
      n_fail++; $display("FAIL midrun_active: conf_seen=%0d busy=%b st=%h required >=0/1/0300", seen, busy, bus.wb_st_rd_addr);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.ddr_ready, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_rd_conf, bus.wb_st_rd_addr,
         ker_valid, busy, done} !== '0 || bus.wb_data_wr !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset_zero: ready=%b en=%h addr=%h conf=%b st=%h kv=%b busy=%b done=%b, required all zero",
               bus.ddr_ready, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_rd_conf, bus.wb_st_rd_addr, ker_valid, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(16'h0040, 16'd1, 11);
    n_checks++;
    if (obs_conf !== 1 || obs_addr[0] !== 16'h0040 || obs_ker !== 1 || obs_done !== 1) begin
      n_fail++; $display("FAIL midrun_rerun: conf=%0d addr=%h ker=%0d done=%0d required 1/0040/1/1",
                         obs_conf, obs_addr[0], obs_ker, obs_done);
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_load_toggle();
    test_load_zero();
    test_run();
    test_run_wrap();
    test_run_zero();
    test_run_first_ignore();
    test_start_priority();
    test_reset_mid_load();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
